// File: rtl/exu_gpr_mp.sv
// rtl/exu_gpr_mp.sv - multi-ported general-purpose register file with scoreboard busy bits
// Combinational reads with optional same-cycle write forwarding; entry 0 is hardwired zero.
module exu_gpr_mp #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD-1:0]      rd_vld,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_wen,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_addr
);

  localparam int DEPTH = 1 << AW;

  logic [XLEN-1:0]  mem [DEPTH];
  logic [DEPTH-1:0] busy;

  // Per-port effective write strobes: address zero never commits.
  logic [NWR-1:0] wr_hit;

  always_comb begin
    wr_hit = '0;
    for (int w = 0; w < NWR; w++) begin
      wr_hit[w] = wr_wen[w] && (wr_addr[w*AW +: AW] != '0);
    end
  end

  logic sb_hit;
  assign sb_hit = sb_set && (sb_addr != '0);

  // Later write ports are assigned last so the highest-numbered port wins a conflict,
  // and the scoreboard set follows the clears so set beats clear on the same entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      busy <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_hit[w]) begin
          mem[wr_addr[w*AW +: AW]]  <= wr_data[w*XLEN +: XLEN];
          busy[wr_addr[w*AW +: AW]] <= 1'b0;
        end
      end
      if (sb_hit) begin
        busy[sb_addr] <= 1'b1;
      end
    end
  end

  genvar p;
  generate
    for (p = 0; p < NRD; p++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] rdat;
      logic            rbsy;

      assign ra = rd_addr[p*AW +: AW];

      always_comb begin
        rdat = '0;
        rbsy = 1'b0;
        if (rd_vld[p] && (ra != '0)) begin
          rdat = mem[ra];
          rbsy = busy[ra];
          if (BYPASS != 0) begin
            for (int w = 0; w < NWR; w++) begin
              if (wr_hit[w] && (wr_addr[w*AW +: AW] == ra)) begin
                rdat = wr_data[w*XLEN +: XLEN];
                rbsy = sb_hit && (sb_addr == ra);
              end
            end
          end
        end
      end

      assign rd_data[p*XLEN +: XLEN] = rdat;
      assign rd_busy[p]              = rbsy;
    end
  endgenerate

endmodule

// File: tb/tb_exu_gpr_mp.sv
// tb/tb_exu_gpr_mp.sv - directed self-checking bench for exu_gpr_mp
// Two instances share stimulus: u_byp forwards (BYPASS=1), u_nob does not (BYPASS=0).
module tb_exu_gpr_mp;

  logic        clk;
  logic        rst;
  logic [1:0]  rd_vld;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  rd_busy_b, rd_busy_n;
  logic [1:0]  wr_wen;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        sb_set;
  logic [4:0]  sb_addr;

  int checks = 0;
  int errors = 0;

  exu_gpr_mp #(.XLEN(32), .AW(5), .NRD(2), .NWR(2), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .rd_vld(rd_vld), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b), .wr_wen(wr_wen), .wr_addr(wr_addr), .wr_data(wr_data),
    .sb_set(sb_set), .sb_addr(sb_addr)
  );

  exu_gpr_mp #(.XLEN(32), .AW(5), .NRD(2), .NWR(2), .BYPASS(0)) u_nob (
    .clk(clk), .rst(rst), .rd_vld(rd_vld), .rd_addr(rd_addr), .rd_data(rd_data_n),
    .rd_busy(rd_busy_n), .wr_wen(wr_wen), .wr_addr(wr_addr), .wr_data(wr_data),
    .sb_set(sb_set), .sb_addr(sb_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] db(input int p);
    return rd_data_b[p*32 +: 32];
  endfunction

  function automatic logic [31:0] dn(input int p);
    return rd_data_n[p*32 +: 32];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  task automatic set_rd(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1);
    rd_vld  = v;
    rd_addr = {a1, a0};
  endtask

  task automatic set_wr(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                        input logic [4:0] a1, input logic [31:0] d1);
    wr_wen  = en;
    wr_addr = {a1, a0};
    wr_data = {d1, d0};
  endtask

  task automatic set_sb(input logic s, input logic [4:0] a);
    sb_set  = s;
    sb_addr = a;
  endtask

  task automatic idle;
    set_rd(2'b00, 5'd0, 5'd0);
    set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    set_sb(1'b0, 5'd0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    set_rd(2'b11, 5'd5, 5'd0);
    settle();
    checks++; if (db(0) !== 32'h0) begin errors++; $display("FAIL reset_init_data got %h exp %h", db(0), 32'h0); end
    checks++; if (rd_busy_b !== 2'b00) begin errors++; $display("FAIL reset_init_busy got %b exp %b", rd_busy_b, 2'b00); end
    tick();
    set_wr(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
    tick();
    set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    set_rd(2'b01, 5'd5, 5'd0);
    settle();
    checks++; if (dn(0) !== 32'hDEADBEEF) begin errors++; $display("FAIL reset_x5_written got %h exp %h", dn(0), 32'hDEADBEEF); end
    tick();
    // reset cycle with a competing write and set; reads still see pre-edge state
    rst = 1'b1;
    set_wr(2'b01, 5'd6, 32'h66, 5'd0, 32'h0);
    set_sb(1'b1, 5'd6);
    set_rd(2'b10, 5'd0, 5'd5);
    settle();
    checks++; if (dn(1) !== 32'hDEADBEEF) begin errors++; $display("FAIL reset_preedge_read got %h exp %h", dn(1), 32'hDEADBEEF); end
    tick();
    rst = 1'b0;
    set_wr(2'b01, 5'd11, 32'h11, 5'd0, 32'h0);
    set_sb(1'b1, 5'd12);
    set_rd(2'b11, 5'd5, 5'd6);
    settle();
    checks++; if (dn(0) !== 32'h0) begin errors++; $display("FAIL reset_x5_cleared got %h exp %h", dn(0), 32'h0); end
    checks++; if (dn(1) !== 32'h0) begin errors++; $display("FAIL reset_x6_write_blocked got %h exp %h", dn(1), 32'h0); end
    checks++; if (rd_busy_n !== 2'b00) begin errors++; $display("FAIL reset_busy_cleared got %b exp %b", rd_busy_n, 2'b00); end
    tick();
    idle();
    set_rd(2'b11, 5'd11, 5'd12);
    settle();
    checks++; if (dn(0) !== 32'h11) begin errors++; $display("FAIL reset_first_write got %h exp %h", dn(0), 32'h11); end
    checks++; if (rd_busy_n !== 2'b10) begin errors++; $display("FAIL reset_first_set got %b exp %b", rd_busy_n, 2'b10); end
    tick();
  endtask

  task automatic test_zero;
    idle();
    set_wr(2'b01, 5'd0, 32'h1234, 5'd0, 32'h0);
    set_sb(1'b1, 5'd0);
    set_rd(2'b01, 5'd0, 5'd0);
    settle();
    checks++; if (db(0) !== 32'h0) begin errors++; $display("FAIL zero_fwd_data got %h exp %h", db(0), 32'h0); end
    tick();
    idle();
    set_rd(2'b11, 5'd0, 5'd0);
    settle();
    checks++; if (rd_data_n !== 64'h0) begin errors++; $display("FAIL zero_data got %h exp %h", rd_data_n, 64'h0); end
    checks++; if (rd_busy_n !== 2'b00) begin errors++; $display("FAIL zero_busy got %b exp %b", rd_busy_n, 2'b00); end
    tick();
  endtask

  task automatic test_forward;
    idle();
    set_wr(2'b01, 5'd7, 32'hA5A5A5A5, 5'd0, 32'h0);
    set_rd(2'b10, 5'd0, 5'd7);
    settle();
    checks++; if (db(1) !== 32'hA5A5A5A5) begin errors++; $display("FAIL fwd_bypass got %h exp %h", db(1), 32'hA5A5A5A5); end
    checks++; if (dn(1) !== 32'h0) begin errors++; $display("FAIL fwd_nobypass_old got %h exp %h", dn(1), 32'h0); end
    tick();
    set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    settle();
    checks++; if (dn(1) !== 32'hA5A5A5A5) begin errors++; $display("FAIL fwd_nobypass_next got %h exp %h", dn(1), 32'hA5A5A5A5); end
    tick();
  endtask

  task automatic test_scoreboard;
    idle();
    set_sb(1'b1, 5'd3);
    set_rd(2'b01, 5'd3, 5'd0);
    settle();
    checks++; if (rd_busy_b[0] !== 1'b0) begin errors++; $display("FAIL sb_not_yet got %b exp %b", rd_busy_b[0], 1'b0); end
    tick();
    set_sb(1'b0, 5'd0);
    settle();
    checks++; if (rd_busy_n[0] !== 1'b1) begin errors++; $display("FAIL sb_set got %b exp %b", rd_busy_n[0], 1'b1); end
    tick();
    set_wr(2'b01, 5'd3, 32'h33, 5'd0, 32'h0);
    set_sb(1'b1, 5'd3);
    settle();
    checks++; if (rd_busy_b[0] !== 1'b1) begin errors++; $display("FAIL sb_fwd_setwins got %b exp %b", rd_busy_b[0], 1'b1); end
    checks++; if (db(0) !== 32'h33) begin errors++; $display("FAIL sb_fwd_data got %h exp %h", db(0), 32'h33); end
    tick();
    set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    set_sb(1'b0, 5'd0);
    settle();
    checks++; if (rd_busy_n[0] !== 1'b1) begin errors++; $display("FAIL sb_setwins got %b exp %b", rd_busy_n[0], 1'b1); end
    checks++; if (dn(0) !== 32'h33) begin errors++; $display("FAIL sb_data33 got %h exp %h", dn(0), 32'h33); end
    tick();
    set_wr(2'b10, 5'd0, 32'h0, 5'd3, 32'h44);
    settle();
    checks++; if (rd_busy_b[0] !== 1'b0) begin errors++; $display("FAIL sb_fwd_clear got %b exp %b", rd_busy_b[0], 1'b0); end
    checks++; if (rd_busy_n[0] !== 1'b1) begin errors++; $display("FAIL sb_nob_preedge got %b exp %b", rd_busy_n[0], 1'b1); end
    tick();
    set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    settle();
    checks++; if (rd_busy_n[0] !== 1'b0) begin errors++; $display("FAIL sb_clear got %b exp %b", rd_busy_n[0], 1'b0); end
    checks++; if (dn(0) !== 32'h44) begin errors++; $display("FAIL sb_data44 got %h exp %h", dn(0), 32'h44); end
    tick();
  endtask

  task automatic test_conflict;
    idle();
    set_wr(2'b11, 5'd9, 32'h1, 5'd9, 32'h2);
    set_rd(2'b01, 5'd9, 5'd0);
    settle();
    checks++; if (db(0) !== 32'h2) begin errors++; $display("FAIL conflict_fwd got %h exp %h", db(0), 32'h2); end
    tick();
    set_wr(2'b11, 5'd13, 32'hA, 5'd14, 32'hB);
    settle();
    checks++; if (dn(0) !== 32'h2) begin errors++; $display("FAIL conflict_stored got %h exp %h", dn(0), 32'h2); end
    tick();
    set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    set_rd(2'b11, 5'd13, 5'd14);
    settle();
    checks++; if (rd_data_n !== {32'hB, 32'hA}) begin errors++; $display("FAIL dual_write got %h exp %h", rd_data_n, {32'hB, 32'hA}); end
    tick();
  endtask

  task automatic test_gating;
    idle();
    set_wr(2'b01, 5'd4, 32'hFFFFFFFF, 5'd0, 32'h0);
    set_sb(1'b1, 5'd4);
    tick();
    set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    set_sb(1'b0, 5'd0);
    set_rd(2'b00, 5'd4, 5'd4);
    settle();
    checks++; if (rd_data_b !== 64'h0) begin errors++; $display("FAIL gate_data got %h exp %h", rd_data_b, 64'h0); end
    checks++; if (rd_busy_b !== 2'b00) begin errors++; $display("FAIL gate_busy got %b exp %b", rd_busy_b, 2'b00); end
    tick();
    set_rd(2'b11, 5'd4, 5'd4);
    settle();
    checks++; if (rd_data_n !== 64'hFFFFFFFF_FFFFFFFF) begin errors++; $display("FAIL gate_open_data got %h exp %h", rd_data_n, 64'hFFFFFFFF_FFFFFFFF); end
    checks++; if (rd_busy_n !== 2'b11) begin errors++; $display("FAIL gate_open_busy got %b exp %b", rd_busy_n, 2'b11); end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [31:0] prev;
    idle();
    prev = 32'h0;
    set_rd(2'b10, 5'd0, 5'd10);
    for (int i = 0; i < 4; i++) begin
      set_wr(2'b01, 5'd10, 32'h100 + i, 5'd0, 32'h0);
      settle();
      checks++; if (db(1) !== 32'h100 + i) begin errors++; $display("FAIL b2b_fwd%0d got %h exp %h", i, db(1), 32'h100 + i); end
      checks++; if (dn(1) !== prev) begin errors++; $display("FAIL b2b_old%0d got %h exp %h", i, dn(1), prev); end
      prev = 32'h100 + i;
      tick();
    end
    set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    settle();
    checks++; if (dn(1) !== 32'h103) begin errors++; $display("FAIL b2b_final got %h exp %h", dn(1), 32'h103); end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_zero();
    test_forward();
    test_scoreboard();
    test_conflict();
    test_gating();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
